// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction-fetch and load/store ports; one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data port has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic [3:0]        d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;
  typedef enum logic {PORT_IF, PORT_D} port_e;

  state_e             state, state_n;
  port_e              win, win_n;
  logic               was_wr, was_wr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               pick_d;

  logic               if_ready_n, if_rvalid_n, d_ready_n, d_rvalid_n, mem_en_n;
  logic [DATA_W-1:0]  if_rdata_n, d_rdata_n, mem_wdata_n;
  logic [3:0]         mem_we_n;
  logic [ADDR_W-1:0]  mem_addr_n;

`ifdef MEM_ARB_RR_EN
  port_e last_grant, last_grant_n;

  // On a tie the port that did not win last time goes first.
  always_comb pick_d = d_req && (!if_req || last_grant == PORT_IF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= PORT_D;
    else     last_grant <= last_grant_n;
  end

  always_comb begin
    last_grant_n = last_grant;
    if (state == S_IDLE && (if_req || d_req))
      last_grant_n = pick_d ? PORT_D : PORT_IF;
  end
`else
  always_comb pick_d = d_req;
`endif

  always_comb begin
    state_n     = state;
    win_n       = win;
    was_wr_n    = was_wr;
    cnt_n       = cnt;
    if_ready_n  = 1'b0;
    if_rvalid_n = 1'b0;
    d_ready_n   = 1'b0;
    d_rvalid_n  = 1'b0;
    mem_en_n    = 1'b0;
    mem_we_n    = '0;
    if_rdata_n  = if_rdata;
    d_rdata_n   = d_rdata;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    unique case (state)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_n     = S_WAIT;
          win_n       = pick_d ? PORT_D : PORT_IF;
          was_wr_n    = pick_d && (|d_we);
          cnt_n       = CNT_W'(MEM_LAT);
          mem_en_n    = 1'b1;
          mem_we_n    = pick_d ? d_we : 4'b0000;
          mem_addr_n  = pick_d ? d_addr : if_addr;
          mem_wdata_n = pick_d ? d_wdata : '0;
          d_ready_n   = pick_d;
          if_ready_n  = !pick_d;
        end
      end
      S_WAIT: begin
        // Counter is zero in the cycle mem_rdata is valid, so capture on that edge.
        if (cnt == '0) begin
          state_n = S_IDLE;
          if (win == PORT_D) begin
            d_rdata_n  = was_wr ? '0 : mem_rdata;
            d_rvalid_n = 1'b1;
          end else begin
            if_rdata_n  = mem_rdata;
            if_rvalid_n = 1'b1;
          end
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      win       <= PORT_IF;
      was_wr    <= 1'b0;
      cnt       <= '0;
      if_ready  <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_ready   <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_n;
      win       <= win_n;
      was_wr    <= was_wr_n;
      cnt       <= cnt_n;
      if_ready  <= if_ready_n;
      if_rvalid <= if_rvalid_n;
      if_rdata  <= if_rdata_n;
      d_ready   <= d_ready_n;
      d_rvalid  <= d_rvalid_n;
      d_rdata   <= d_rdata_n;
      mem_en    <= mem_en_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1 and one at MEM_LAT=3, each with a RAM model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] ram_rd(input logic [15:0] a);
    case (a)
      16'h0010: ram_rd = 32'h00A00093;
      16'h0004: ram_rd = 32'h12345678;
      default:  ram_rd = 32'h0;
    endcase
  endfunction

  // MEM_LAT=1 instance
  logic        l1_if_req = 0, l1_if_ready, l1_if_rvalid;
  logic [15:0] l1_if_addr = 0;
  logic [31:0] l1_if_rdata;
  logic        l1_d_req = 0, l1_d_ready, l1_d_rvalid;
  logic [3:0]  l1_d_we = 0;
  logic [15:0] l1_d_addr = 0;
  logic [31:0] l1_d_wdata = 0, l1_d_rdata;
  logic        l1_mem_en;
  logic [3:0]  l1_mem_we;
  logic [15:0] l1_mem_addr;
  logic [31:0] l1_mem_wdata, l1_mem_rdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1)) u_l1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_ready(l1_if_ready),
    .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_ready(l1_d_ready), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
  );

  // MEM_LAT=3 instance
  logic        l3_if_req = 0, l3_if_ready, l3_if_rvalid;
  logic [15:0] l3_if_addr = 0;
  logic [31:0] l3_if_rdata;
  logic        l3_d_req = 0, l3_d_ready, l3_d_rvalid;
  logic [3:0]  l3_d_we = 0;
  logic [15:0] l3_d_addr = 0;
  logic [31:0] l3_d_wdata = 0, l3_d_rdata;
  logic        l3_mem_en;
  logic [3:0]  l3_mem_we;
  logic [15:0] l3_mem_addr;
  logic [31:0] l3_mem_wdata, l3_mem_rdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(3)) u_l3 (
    .clk(clk), .rst(rst),
    .if_req(l3_if_req), .if_addr(l3_if_addr), .if_ready(l3_if_ready),
    .if_rvalid(l3_if_rvalid), .if_rdata(l3_if_rdata),
    .d_req(l3_d_req), .d_we(l3_d_we), .d_addr(l3_d_addr), .d_wdata(l3_d_wdata),
    .d_ready(l3_d_ready), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata),
    .mem_en(l3_mem_en), .mem_we(l3_mem_we), .mem_addr(l3_mem_addr),
    .mem_wdata(l3_mem_wdata), .mem_rdata(l3_mem_rdata)
  );

  // RAM models: data is valid only in cycle C+MEM_LAT, garbage otherwise.
  logic [31:0] p1;
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    p1    <= l1_mem_en ? ram_rd(l1_mem_addr) : 32'hBAD0BAD0;
    p3[0] <= l3_mem_en ? ram_rd(l3_mem_addr) : 32'hBAD0BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign l1_mem_rdata = p1;
  assign l3_mem_rdata = p3[2];

  // Per-cycle protocol scoreboard
  int o1 = 0;
  int o3 = 0;
  always @(negedge clk) begin
    if (rst) begin
      o1 = 0;
      o3 = 0;
    end else begin
      check("l1_both_ready", 32'(l1_if_ready & l1_d_ready), 32'd0);
      check("l1_both_rvalid", 32'(l1_if_rvalid & l1_d_rvalid), 32'd0);
      check("l1_en_vs_ready", 32'(l1_mem_en), 32'(l1_if_ready | l1_d_ready));
      if (l1_if_rvalid || l1_d_rvalid) begin
        check("l1_rvalid_outst", o1, 32'd1);
        o1--;
      end
      if (l1_if_ready || l1_d_ready) begin
        check("l1_ready_outst", o1, 32'd0);
        o1++;
      end
      check("l3_both_ready", 32'(l3_if_ready & l3_d_ready), 32'd0);
      check("l3_both_rvalid", 32'(l3_if_rvalid & l3_d_rvalid), 32'd0);
      check("l3_en_vs_ready", 32'(l3_mem_en), 32'(l3_if_ready | l3_d_ready));
      if (l3_if_rvalid || l3_d_rvalid) begin
        check("l3_rvalid_outst", o3, 32'd1);
        o3--;
      end
      if (l3_if_ready || l3_d_ready) begin
        check("l3_ready_outst", o3, 32'd0);
        o3++;
      end
    end
  end

  initial begin
    step(2);
    check("rst_ctl", 32'({l1_if_ready, l1_if_rvalid, l1_d_ready, l1_d_rvalid, l1_mem_en, l1_mem_we}), 32'd0);
    check("rst_if_rdata", l1_if_rdata, 32'd0);
    check("rst_d_rdata", l1_d_rdata, 32'd0);
    check("rst_mem_addr", 32'(l1_mem_addr), 32'd0);
    check("rst_mem_wdata", l1_mem_wdata, 32'd0);
    rst = 1'b0;
    step(1);

    // 1: fetch at LAT=1
    l1_if_req = 1; l1_if_addr = 16'h0010;
    step(1);
    check("t1_if_ready", 32'(l1_if_ready), 32'd1);
    check("t1_mem_en", 32'(l1_mem_en), 32'd1);
    check("t1_mem_addr", 32'(l1_mem_addr), 32'h0010);
    check("t1_mem_we", 32'(l1_mem_we), 32'd0);
    l1_if_req = 0;
    step(1);
    check("t1_rvalid_early", 32'(l1_if_rvalid), 32'd0);
    check("t1_en_once", 32'(l1_mem_en), 32'd0);
    step(1);
    check("t1_if_rvalid", 32'(l1_if_rvalid), 32'd1);
    check("t1_if_rdata", l1_if_rdata, 32'h00A00093);
    step(1);
    check("t1_rvalid_pulse", 32'(l1_if_rvalid), 32'd0);
    check("t1_rdata_hold", l1_if_rdata, 32'h00A00093);

    // data read, then 2: byte write
    l1_d_req = 1; l1_d_we = 4'b0000; l1_d_addr = 16'h0010;
    step(1);
    check("dr_d_ready", 32'(l1_d_ready), 32'd1);
    l1_d_req = 0;
    step(2);
    check("dr_d_rvalid", 32'(l1_d_rvalid), 32'd1);
    check("dr_d_rdata", l1_d_rdata, 32'h00A00093);
    step(1);
    l1_d_req = 1; l1_d_we = 4'b0001; l1_d_addr = 16'h0200; l1_d_wdata = 32'h000000AB;
    step(1);
    check("t2_d_ready", 32'(l1_d_ready), 32'd1);
    check("t2_mem_en", 32'(l1_mem_en), 32'd1);
    check("t2_mem_we", 32'(l1_mem_we), 32'h1);
    check("t2_mem_addr", 32'(l1_mem_addr), 32'h0200);
    check("t2_mem_wdata", l1_mem_wdata, 32'h000000AB);
    l1_d_req = 0;
    step(1);
    check("t2_mem_we_off", 32'(l1_mem_we), 32'd0);
    check("t2_mem_addr_hold", 32'(l1_mem_addr), 32'h0200);
    step(1);
    check("t2_d_rvalid", 32'(l1_d_rvalid), 32'd1);
    check("t2_d_rdata", l1_d_rdata, 32'd0);
    check("t2_loser_rdata", l1_if_rdata, 32'h00A00093);
    step(1);

    // 3: simultaneous requests, 4 grants
    l1_if_req = 1; l1_if_addr = 16'h0010;
    l1_d_req = 1; l1_d_we = 4'b0000; l1_d_addr = 16'h0004;
    step(1);
    for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
      check($sformatf("t3_if_grant%0d", g), 32'(l1_if_ready), (g % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t3_d_grant%0d", g), 32'(l1_d_ready), (g % 2 == 0) ? 32'd0 : 32'd1);
`else
      check($sformatf("t3_if_grant%0d", g), 32'(l1_if_ready), 32'd0);
      check($sformatf("t3_d_grant%0d", g), 32'(l1_d_ready), 32'd1);
`endif
      if (g == 3) begin
        l1_if_req = 0;
        l1_d_req = 0;
      end
      step(3);
    end
    check("t3_d_rdata", l1_d_rdata, 32'h12345678);

    // 4: LAT=3 read with fetch raised during WAIT
    l3_d_req = 1; l3_d_we = 4'b0000; l3_d_addr = 16'h0004;
    step(1);
    check("t4_d_ready", 32'(l3_d_ready), 32'd1);
    l3_d_req = 0; l3_if_req = 1; l3_if_addr = 16'h0010;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      check($sformatf("t4_no_rvalid_c%0d", k), 32'(l3_d_rvalid), 32'd0);
      check($sformatf("t4_no_if_grant_c%0d", k), 32'(l3_if_ready), 32'd0);
    end
    step(1);
    check("t4_d_rvalid", 32'(l3_d_rvalid), 32'd1);
    check("t4_d_rdata", l3_d_rdata, 32'h12345678);
    check("t4_if_wait", 32'(l3_if_ready), 32'd0);
    step(1);
    check("t4_if_ready", 32'(l3_if_ready), 32'd1);
    l3_if_req = 0;
    step(4);
    check("t4_if_rvalid", 32'(l3_if_rvalid), 32'd1);
    check("t4_if_rdata", l3_if_rdata, 32'h00A00093);
    step(1);

    // 5: reset mid-transaction
    l1_d_req = 1; l1_d_we = 4'b0000; l1_d_addr = 16'h0004;
    step(1);
    check("t5_d_ready", 32'(l1_d_ready), 32'd1);
    l1_d_req = 0; l1_if_req = 1; l1_if_addr = 16'h0010;
    step(1);
    rst = 1'b1;
    #1;
    check("t5_rst_ctl", 32'({l1_if_ready, l1_if_rvalid, l1_d_ready, l1_d_rvalid, l1_mem_en, l1_mem_we}), 32'd0);
    check("t5_rst_if_rdata", l1_if_rdata, 32'd0);
    check("t5_rst_d_rdata", l1_d_rdata, 32'd0);
    check("t5_rst_mem_addr", 32'(l1_mem_addr), 32'd0);
    check("t5_rst_mem_wdata", l1_mem_wdata, 32'd0);
    step(1);
    check("t5_no_rvalid_rst", 32'(l1_d_rvalid), 32'd0);
    rst = 1'b0;
    step(1);
    check("t5_if_ready", 32'(l1_if_ready), 32'd1);
    check("t5_no_d_rvalid", 32'(l1_d_rvalid), 32'd0);
    check("t5_mem_addr", 32'(l1_mem_addr), 32'h0010);
    l1_if_req = 0;
    step(2);
    check("t5_if_rvalid", 32'(l1_if_rvalid), 32'd1);
    check("t5_if_rdata", l1_if_rdata, 32'h00A00093);
    check("t5_d_rdata_hold", l1_d_rdata, 32'd0);
    step(2);

    check("end_l1_outst", o1, 32'd0);
    check("end_l3_outst", o3, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
